// File: rtl/cpsr_flag_register_if.sv
// Bus for the status-flag register: upstream flag handshake, condition query and save-stack control.
// The sticky-Q signals exist only when CPSR_STICKY_Q_EN is defined.
interface cpsr_flag_register_if;
   logic       negative;
   logic       zero;
   logic       cout;
   logic       overflow;
   logic       flags_valid;
   logic       flags_ready;
   logic [3:0] update_mask;
   logic [3:0] cond;
   logic       cond_pass;
   logic       push;
   logic       pop;
   logic [3:0] flags_q;
   logic       stack_full;
   logic       stack_empty;
   logic       stack_err;
   logic       err_clr;
`ifdef CPSR_STICKY_Q_EN
   logic       sticky_q;
   logic       q_clr;
`endif

   modport master (
      output negative, zero, cout, overflow, flags_valid, update_mask, cond, push, pop, err_clr,
`ifdef CPSR_STICKY_Q_EN
      output q_clr,
      input  sticky_q,
`endif
      input  flags_ready, cond_pass, flags_q, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  negative, zero, cout, overflow, flags_valid, update_mask, cond, push, pop, err_clr,
`ifdef CPSR_STICKY_Q_EN
      input  q_clr,
      output sticky_q,
`endif
      output flags_ready, cond_pass, flags_q, stack_full, stack_empty, stack_err
   );
endinterface

// File: rtl/cpsr_flag_register.sv
// NZCV status register with masked capture, condition-code evaluation and a save/restore stack.
// Define CPSR_STICKY_Q_EN to add a sticky overflow bit (sticky_q/q_clr) carried through the stack.
module cpsr_flag_register #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 3
) (
   input logic                 clk,
   input logic                 reset_n,
   cpsr_flag_register_if.slave bus
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CPSR_STICKY_Q_EN
   localparam int unsigned ENTRY_W = 5;
`else
   localparam int unsigned ENTRY_W = 4;
`endif

   typedef enum logic [1:0] {StReset, StRun, StErr} state_e;

   state_e             state_q;
   logic               run_q;
   logic               err_q;
   logic [3:0]         nzcv_q, nzcv_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [ENTRY_W-1:0] stack_q [DEPTH];
   logic [ENTRY_W-1:0] cur_entry;
   logic [ENTRY_W-1:0] top_entry;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   top_idx;
   logic [3:0]         flags_in;
   logic               ready;
   logic               xfer;
   logic               full;
   logic               empty;
   logic               push_req;
   logic               pop_req;
   logic               push_ok;
   logic               pop_ok;
   logic               err_set;
   logic               pass;

   assign flags_in = {bus.negative, bus.zero, bus.cout, bus.overflow};
   assign full     = (ptr_q == PTR_W'(DEPTH));
   assign empty    = (ptr_q == '0);

   // Pop owns the flag write port for its cycle, so upstream is stalled.
   assign ready = run_q & ~bus.pop;
   assign xfer  = bus.flags_valid & ready;

   // Simultaneous push and pop is illegal and performs neither.
   assign push_req = bus.push & ~bus.pop;
   assign pop_req  = bus.pop & ~bus.push;
   assign push_ok  = push_req & ~full;
   assign pop_ok   = pop_req & ~empty;
   assign err_set  = (bus.push & bus.pop) | (push_req & full) | (pop_req & empty);

   assign wr_idx    = IDX_W'(ptr_q);
   assign top_idx   = IDX_W'(ptr_q - 1'b1);
   assign top_entry = stack_q[top_idx];

   always_comb begin
      nzcv_d = nzcv_q;
      if (pop_ok) begin
         nzcv_d = top_entry[3:0];
      end else if (xfer) begin
         nzcv_d = (nzcv_q & ~bus.update_mask) | (flags_in & bus.update_mask);
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (push_ok) begin
         ptr_d = ptr_q + 1'b1;
      end else if (pop_ok) begin
         ptr_d = ptr_q - 1'b1;
      end
   end

`ifdef CPSR_STICKY_Q_EN
   logic sticky_q, sticky_d;
   logic sticky_set;

   assign sticky_set = xfer & bus.overflow & bus.update_mask[0];
   assign cur_entry  = {sticky_q, nzcv_q};

   always_comb begin
      sticky_d = sticky_q;
      if (pop_ok) begin
         sticky_d = top_entry[4];
      end else if (sticky_set) begin
         sticky_d = 1'b1;
      end else if (bus.q_clr) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign bus.sticky_q = sticky_q;
`else
   assign cur_entry = nzcv_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nzcv_q <= 4'b0000;
         ptr_q  <= '0;
      end else begin
         nzcv_q <= nzcv_d;
         ptr_q  <= ptr_d;
      end
   end

   // Stack contents carry no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         stack_q[wr_idx] <= cur_entry;
      end
   end

   // Control FSM; run_q doubles as the reset synchroniser for flags_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StReset;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (err_set) begin
            state_q <= StErr;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               StReset: state_q <= StRun;
               StErr: begin
                  if (bus.err_clr) begin
                     state_q <= StRun;
                     err_q   <= 1'b0;
                  end
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

   always_comb begin
      pass = 1'b0;
      unique case (bus.cond)
         4'h0: pass = nzcv_q[2];
         4'h1: pass = ~nzcv_q[2];
         4'h2: pass = nzcv_q[1];
         4'h3: pass = ~nzcv_q[1];
         4'h4: pass = nzcv_q[3];
         4'h5: pass = ~nzcv_q[3];
         4'h6: pass = nzcv_q[0];
         4'h7: pass = ~nzcv_q[0];
         4'h8: pass = nzcv_q[1] & ~nzcv_q[2];
         4'h9: pass = ~nzcv_q[1] | nzcv_q[2];
         4'hA: pass = (nzcv_q[3] == nzcv_q[0]);
         4'hB: pass = (nzcv_q[3] != nzcv_q[0]);
         4'hC: pass = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
         4'hD: pass = nzcv_q[2] | (nzcv_q[3] != nzcv_q[0]);
         4'hE: pass = 1'b1;
         4'hF: pass = 1'b0;
      endcase
   end

   assign bus.flags_ready = ready;
   assign bus.cond_pass   = pass;
   assign bus.flags_q     = nzcv_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.stack_err   = err_q;

   a_ptr_bound: assert property (@(posedge clk) disable iff (!reset_n) ptr_q <= PTR_W'(DEPTH));
   a_no_xfer_on_pop: assert property (@(posedge clk) disable iff (!reset_n) bus.pop |-> !xfer);
   a_err_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
                                         err_q == (state_q == StErr));

endmodule

// File: tb/tb_cpsr_flag_register.sv
// Self-checking bench for cpsr_flag_register: scoreboard of expected flags per transfer/pop,
// plus inline status checks. Sticky-Q scenario is compiled in with CPSR_STICKY_Q_EN.
module tb_cpsr_flag_register;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [3:0] exp_q[$];

   cpsr_flag_register_if bus ();

   cpsr_flag_register #(.DEPTH(4), .PTR_W(3)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.negative = 1'b0;
      bus.zero = 1'b0;
      bus.cout = 1'b0;
      bus.overflow = 1'b0;
      bus.flags_valid = 1'b0;
      bus.update_mask = 4'b0000;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.err_clr = 1'b0;
`ifdef CPSR_STICKY_Q_EN
      bus.q_clr = 1'b0;
`endif
   endtask

   task automatic drive_flags(input logic [3:0] f, input logic [3:0] m);
      {bus.negative, bus.zero, bus.cout, bus.overflow} = f;
      bus.update_mask = m;
      bus.flags_valid = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] st;
      int k;
      idle();
      bus.cond = 4'h0;
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.flags_q !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b expected 0000", bus.flags_q);
      end
      st = {bus.stack_empty, bus.stack_full, bus.flags_ready, bus.stack_err};
      n_cmp++;
      if (st !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_status{empty,full,ready,err}: got %b expected 1000", st);
      end
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      while (bus.flags_ready !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      n_cmp++;
      if (bus.flags_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_after_reset: got %b expected 1", bus.flags_ready);
      end
   endtask

   task automatic test_transfer_cond();
      logic [3:0] e;
      drive_flags(4'b1000, 4'b1111);
      exp_q.push_back(4'b1000);
      tick();
      idle();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.flags_q !== e) begin
         n_bad++;
         $display("FAIL xfer_1000: got %b expected %b", bus.flags_q, e);
      end
      bus.cond = 4'hB;
      #1;
      n_cmp++;
      if (bus.cond_pass !== 1'b1) begin
         n_bad++;
         $display("FAIL cond_LT: got %b expected 1", bus.cond_pass);
      end
      bus.cond = 4'hA;
      #1;
      n_cmp++;
      if (bus.cond_pass !== 1'b0) begin
         n_bad++;
         $display("FAIL cond_GE: got %b expected 0", bus.cond_pass);
      end
   endtask

   task automatic test_mask();
      logic [3:0] e;
      drive_flags(4'b0100, 4'b1111);
      exp_q.push_back(4'b0100);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.flags_q !== e) begin
         n_bad++;
         $display("FAIL mask_load: got %b expected %b", bus.flags_q, e);
      end
      drive_flags(4'b1011, 4'b0011);
      exp_q.push_back(4'b0111);
      tick();
      idle();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.flags_q !== e) begin
         n_bad++;
         $display("FAIL mask_partial: got %b expected %b", bus.flags_q, e);
      end
      bus.cond = 4'h8;
      #1;
      n_cmp++;
      if (bus.cond_pass !== 1'b0) begin
         n_bad++;
         $display("FAIL cond_HI: got %b expected 0", bus.cond_pass);
      end
   endtask

   // Per-pattern truth vectors: bit c is the expected cond_pass for cond=c.
   task automatic test_cond_sweep();
      logic [3:0]  pat [4];
      logic [15:0] vec [4];
      logic [15:0] v;
      pat[0] = 4'b0111; vec[0] = 16'h6A65;
      pat[1] = 4'b1000; vec[1] = 16'h6A9A;
      pat[2] = 4'b0000; vec[2] = 16'h56AA;
      pat[3] = 4'b0010; vec[3] = 16'h55A6;
      for (int p = 0; p < 4; p++) begin
         drive_flags(pat[p], 4'b1111);
         tick();
         idle();
         v = vec[p];
         for (int c = 0; c < 16; c++) begin
            bus.cond = 4'(c);
            #1;
            n_cmp++;
            if (bus.cond_pass !== v[c]) begin
               n_bad++;
               $display("FAIL cond_sweep flags=%b cond=%h: got %b expected %b",
                        pat[p], c, bus.cond_pass, v[c]);
            end
         end
      end
   endtask

   task automatic test_stack();
      logic [3:0] e;
      drive_flags(4'd1, 4'b1111);
      exp_q.push_back(4'd1);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.flags_q !== e) begin
         n_bad++;
         $display("FAIL stack_load1: got %h expected %h", bus.flags_q, e);
      end
      // Push alongside a transfer: the old flags are saved, the new ones still land.
      for (int i = 2; i <= 4; i++) begin
         drive_flags(4'(i), 4'b1111);
         bus.push = 1'b1;
         exp_q.push_back(4'(i));
         tick();
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.flags_q !== e) begin
            n_bad++;
            $display("FAIL stack_push_xfer%0d: got %h expected %h", i, bus.flags_q, e);
         end
      end
      bus.flags_valid = 1'b0;
      bus.push = 1'b1;
      tick();
      idle();
      n_cmp++;
      if ({bus.stack_full, bus.stack_err} !== 2'b10) begin
         n_bad++;
         $display("FAIL stack_full4{full,err}: got %b expected 10",
                  {bus.stack_full, bus.stack_err});
      end
      bus.push = 1'b1;
      tick();
      idle();
      n_cmp++;
      if ({bus.stack_full, bus.stack_err, bus.flags_q} !== 6'b11_0100) begin
         n_bad++;
         $display("FAIL push_overflow{full,err,flags}: got %b expected 110100",
                  {bus.stack_full, bus.stack_err, bus.flags_q});
      end
      for (int i = 4; i >= 1; i--) begin
         bus.pop = 1'b1;
         exp_q.push_back(4'(i));
         tick();
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.flags_q !== e) begin
            n_bad++;
            $display("FAIL stack_pop%0d: got %h expected %h", i, bus.flags_q, e);
         end
      end
      idle();
      n_cmp++;
      if ({bus.stack_empty, bus.stack_full} !== 2'b10) begin
         n_bad++;
         $display("FAIL stack_empty_after_pops: got %b expected 10",
                  {bus.stack_empty, bus.stack_full});
      end
      bus.err_clr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.stack_err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clr: got %b expected 0", bus.stack_err);
      end
      // Underflow with err_clr in the same cycle: the new error wins.
      bus.pop = 1'b1;
      bus.err_clr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if ({bus.stack_err, bus.flags_q} !== 5'b1_0001) begin
         n_bad++;
         $display("FAIL pop_empty{err,flags}: got %b expected 10001",
                  {bus.stack_err, bus.flags_q});
      end
      bus.err_clr = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_pop_stall();
      logic [3:0] e;
      drive_flags(4'h5, 4'b1111);
      tick();
      idle();
      bus.push = 1'b1;
      tick();
      idle();
      drive_flags(4'hA, 4'b1111);
      bus.pop = 1'b1;
      #1;
      n_cmp++;
      if (bus.flags_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL ready_during_pop: got %b expected 0", bus.flags_ready);
      end
      exp_q.push_back(4'h5);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.flags_q !== e) begin
         n_bad++;
         $display("FAIL pop_priority: got %h expected %h", bus.flags_q, e);
      end
      bus.pop = 1'b0;
      #1;
      n_cmp++;
      if (bus.flags_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_after_pop: got %b expected 1", bus.flags_ready);
      end
      exp_q.push_back(4'hA);
      tick();
      idle();
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.flags_q, bus.stack_empty} !== {e, 1'b1}) begin
         n_bad++;
         $display("FAIL stalled_xfer{flags,empty}: got %b expected %b",
                  {bus.flags_q, bus.stack_empty}, {e, 1'b1});
      end
   endtask

   task automatic test_push_pop();
      bus.push = 1'b1;
      tick();
      idle();
      drive_flags(4'h3, 4'b1111);
      bus.push = 1'b1;
      bus.pop = 1'b1;
      tick();
      idle();
      n_cmp++;
      if ({bus.stack_err, bus.stack_empty, bus.stack_full, bus.flags_q} !== 7'b100_1010) begin
         n_bad++;
         $display("FAIL push_pop{err,empty,full,flags}: got %b expected 1001010",
                  {bus.stack_err, bus.stack_empty, bus.stack_full, bus.flags_q});
      end
      bus.err_clr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.stack_err !== 1'b0) begin
         n_bad++;
         $display("FAIL push_pop_clr: got %b expected 0", bus.stack_err);
      end
      drive_flags(4'h6, 4'b1111);
      tick();
      idle();
      bus.pop = 1'b1;
      tick();
      idle();
      n_cmp++;
      if ({bus.flags_q, bus.stack_empty} !== 5'b1010_1) begin
         n_bad++;
         $display("FAIL push_pop_occupancy{flags,empty}: got %b expected 10101",
                  {bus.flags_q, bus.stack_empty});
      end
   endtask

   task automatic test_reset_mid();
      int k;
      drive_flags(4'h6, 4'b1111);
      tick();
      idle();
      bus.push = 1'b1;
      tick();
      tick();
      bus.pop = 1'b1;
      tick();
      idle();
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.flags_q, bus.stack_empty, bus.stack_full, bus.flags_ready, bus.stack_err}
          !== 8'b0000_1000) begin
         n_bad++;
         $display("FAIL reset_mid{flags,empty,full,ready,err}: got %b expected 00001000",
                  {bus.flags_q, bus.stack_empty, bus.stack_full, bus.flags_ready,
                   bus.stack_err});
      end
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      while (bus.flags_ready !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      n_cmp++;
      if (bus.flags_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_after_mid_reset: got %b expected 1", bus.flags_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] m, f, mk, e;
      m = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         f = 4'($urandom_range(0, 15));
         mk = 4'($urandom_range(0, 15));
         drive_flags(f, mk);
         m = (m & ~mk) | (f & mk);
         exp_q.push_back(m);
         tick();
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.flags_q !== e) begin
            n_bad++;
            $display("FAIL back_to_back%0d f=%b m=%b: got %b expected %b",
                     i, f, mk, bus.flags_q, e);
         end
      end
      idle();
   endtask

`ifdef CPSR_STICKY_Q_EN
   task automatic test_sticky();
      drive_flags(4'b0001, 4'b0001);
      tick();
      drive_flags(4'b0000, 4'b0001);
      tick();
      idle();
      n_cmp++;
      if (bus.sticky_q !== 1'b1) begin
         n_bad++;
         $display("FAIL sticky_hold: got %b expected 1", bus.sticky_q);
      end
      bus.push = 1'b1;
      tick();
      idle();
      bus.q_clr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.sticky_q !== 1'b0) begin
         n_bad++;
         $display("FAIL sticky_clr: got %b expected 0", bus.sticky_q);
      end
      bus.pop = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.sticky_q !== 1'b1) begin
         n_bad++;
         $display("FAIL sticky_pop: got %b expected 1", bus.sticky_q);
      end
      bus.q_clr = 1'b1;
      drive_flags(4'b0001, 4'b0001);
      tick();
      idle();
      n_cmp++;
      if (bus.sticky_q !== 1'b1) begin
         n_bad++;
         $display("FAIL sticky_set_wins: got %b expected 1", bus.sticky_q);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_transfer_cond();
      test_mask();
      test_cond_sweep();
      test_stack();
      test_pop_stall();
      test_push_pop();
      test_reset_mid();
      test_back_to_back();
`ifdef CPSR_STICKY_Q_EN
      test_sticky();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpsr_flag_register.md
Name: cpsr_flag_register

Overview:
- Status-flag stage directly downstream of the integer comparator/ALU.
- Captures its negative/zero/cout/overflow outputs through a valid/ready handshake, with a per-flag write mask.
- Evaluates 4-bit condition codes against the stored flags.
- Keeps a save/restore stack of flag snapshots for exception/call entry and exit.

Parameters:
- DEPTH, 4, number of entries in the flag save stack (2..16).
- PTR_W, 3, stack pointer width; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- negative  input  1  N flag from upstream
- zero  input  1  Z flag from upstream
- cout  input  1  C flag from upstream
- overflow  input  1  V flag from upstream
- flags_valid  input  1  upstream flags valid this cycle
- flags_ready  output  1  register can accept flags this cycle
- update_mask  input  4  {N,Z,C,V} write enables, sampled with flags_valid
- cond  input  4  condition code to evaluate
- cond_pass  output  1  combinational result of cond against the current flags
- push  input  1  save current flags onto the stack
- pop  input  1  restore flags from the top of the stack
- flags_q  output  4  registered {N,Z,C,V}
- stack_full  output  1  occupancy == DEPTH
- stack_empty  output  1  occupancy == 0
- stack_err  output  1  sticky error flag
- err_clr  input  1  clears stack_err

Behaviour:
Reset and transfer:
- Reset is asynchronous and active-low. While reset_n=0: flags_q=4'b0000, stack occupancy=0, stack_err=0.
- Outputs during reset: stack_empty=1, stack_full=0, flags_ready=0.
- flags_ready = reset synchronised high AND NOT pop. Ready is low in any cycle in which pop is asserted.
- A transfer occurs when flags_valid && flags_ready.
- On a transfer, each flags_q bit whose update_mask bit is 1 takes the corresponding input at the clock edge. Masked bits hold.
- Latency is 1 cycle: new flags are visible on flags_q and cond_pass in the cycle after the transfer.

Condition codes (cond_pass):
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C&!Z
- 9 LS: !C|Z
- A GE: N==V
- B LT: N!=V
- C GT: !Z&(N==V)
- D LE: Z|(N!=V)
- E AL: 1
- F NV: 0

Stack:
- Push, not full: stack[ptr] <= flags_q (the pre-update value), then ptr+1.
- Push and a same-cycle transfer: the push saves the old flags; the transfer still applies to flags_q.
- Pop, not empty: ptr-1, then flags_q <= stack[ptr-1]. A pop has priority over any update, because flags_ready=0.
- Push while full: no stack change, stack_err <= 1. Flags still update if transferred.
- Pop while empty: no change to the stack or flags_q, stack_err <= 1.
- Push and pop in the same cycle: treated as an illegal operation. stack_err <= 1, no stack change, flags_q unchanged (ready is low).
- stack_err clears on err_clr when no new error occurs in the same cycle; a new error wins.

Control state machine:
- RESET: reset_n low.
- RUN: default state.
- ERR: stack_err set. Returns to RUN on err_clr.
- Normal operation (transfers, push, pop) continues in ERR.

Reset mid-operation:
- Occupancy, flags and error are cleared immediately. Stack contents need not be cleared.

Optional Feature:
- Macro: CPSR_STICKY_Q_EN.
- When defined, add output sticky_q (1 bit) and input q_clr (1 bit).
  - sticky_q sets on any transfer with overflow=1 and update_mask[0]=1.
  - sticky_q holds until q_clr or reset.
  - sticky_q is pushed and popped with the flags, so stack entries are 5 bits wide.
  - q_clr and a set condition in the same cycle: set wins.
- When undefined, neither port exists and stack entries are 4 bits.

Test Plan:
- Reset release, then a transfer {N,Z,C,V}=1,0,0,0 with mask 4'b1111 -> next cycle flags_q=4'b1000; cond=B (LT) gives cond_pass=1, cond=A (GE) gives cond_pass=0.
- flags_q=4'b0100, transfer 4'b1011 with mask 4'b0011 -> flags_q=4'b0111; cond=8 (HI) gives cond_pass=0.
- Push DEPTH=4 times with flags 1,2,3,4, a fifth push -> stack_full=1, stack_err=1. Then pop 4 times -> flags_q=4,3,2,1, stack_empty=1.
- Pop asserted together with flags_valid -> flags_ready=0, flags_q takes the stack value, the upstream transfer stalls one cycle, then completes.
- Push and pop together -> stack_err=1, occupancy unchanged; err_clr next cycle -> stack_err=0.
- reset_n pulsed low mid-cycle with occupancy 2 -> immediately flags_q=0, stack_empty=1, stack_err=0. (With CPSR_STICKY_Q_EN: a V=1 transfer sets sticky_q, which holds after a V=0 transfer.)
